render_sequencer: RTL

- Frame-level controller for the plotter render pipeline. Per redraw it runs: fill_drawer clear → logic plot (logic drives line_drawer) → frame_buffer swap aligned to vsync.
- Owns the single frame_buffer write port and multiplexes fill_drawer and line_drawer writes by phase, replacing the OR-combine of the two write ports.
- Coalesces redraw requests, counts completed frames and flags hung sub-blocks.

---
 rtl/render_sequencer_if.sv | 44 ++++
 rtl/render_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/render_sequencer_if.sv
// Sequencer-facing bundle: redraw/vsync control, fill and logic
// handshakes, the two drawer write ports and the frame_buffer write port.
interface render_sequencer_if #(
   parameter int ADDR_WIDTH        = 19,
   parameter int FRAME_COUNT_WIDTH = 16
);
   logic                         redraw_req;
   logic                         vsync;
   logic                         fill_start;
   logic                         fill_ready;
   logic                         logic_start;
   logic                         logic_ready;
   logic                         swap;
   logic                         fill_we;
   logic [ADDR_WIDTH-1:0]        fill_addr;
   logic                         fill_data;
   logic                         line_we;
   logic [ADDR_WIDTH-1:0]        line_addr;
   logic                         line_data;
   logic                         fb_we;
   logic [ADDR_WIDTH-1:0]        fb_addr;
   logic                         fb_data;
   logic                         busy;
   logic                         error;
   logic [FRAME_COUNT_WIDTH-1:0] frame_count;

   modport master (
      output redraw_req, vsync, fill_ready, logic_ready,
      output fill_we, fill_addr, fill_data,
      output line_we, line_addr, line_data,
      input  fill_start, logic_start, swap,
      input  fb_we, fb_addr, fb_data,
      input  busy, error, frame_count
   );

   modport slave (
      input  redraw_req, vsync, fill_ready, logic_ready,
      input  fill_we, fill_addr, fill_data,
      input  line_we, line_addr, line_data,
      output fill_start, logic_start, swap,
      output fb_we, fb_addr, fb_data,
      output busy, error, frame_count
   );
endinterface

// File: rtl/render_sequencer.sv
// Frame-level render controller: clear, plot, vsync-aligned swap,
// with redraw coalescing, a per-phase watchdog and the fb write mux.
module render_sequencer #(
   parameter int ADDR_WIDTH        = 19,
   parameter int FRAME_COUNT_WIDTH = 16,
   parameter int TIMEOUT_CYCLES    = 2000000
) (
   input logic              clk,
   input logic              rst,
   render_sequencer_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE,
      CLEAR_START,
      CLEAR_ARM,
      CLEAR_WAIT,
      PLOT_START,
      PLOT_ARM,
      PLOT_WAIT,
      SWAP_WAIT,
      SWAP
   } state_t;

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t                       state;
   state_t                       state_d;
   logic [WD_W-1:0]              wd;
   logic                         pending;
   logic                         error_q;
   logic                         fill_start_q;
   logic                         logic_start_q;
   logic [FRAME_COUNT_WIDTH-1:0] frames;

   logic fill_start_d;
   logic logic_start_d;
   logic wd_clr;
   logic timeout;
   logic accept;

   always_comb begin
      state_d       = state;
      fill_start_d  = 1'b0;
      logic_start_d = 1'b0;
      wd_clr        = 1'b0;
      timeout       = 1'b0;
      accept        = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.redraw_req || pending) begin
               accept  = 1'b1;
               state_d = CLEAR_START;
            end
         end
         CLEAR_START: begin
            if (bus.fill_ready) begin
               fill_start_d = 1'b1;
               state_d      = CLEAR_ARM;
            end
         end
         // ready may still read high from before the start was seen
         CLEAR_ARM: begin
            wd_clr  = 1'b1;
            state_d = CLEAR_WAIT;
         end
         CLEAR_WAIT: begin
            if (bus.fill_ready) begin
               state_d = PLOT_START;
            end else if (wd == WD_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         PLOT_START: begin
            if (bus.logic_ready) begin
               logic_start_d = 1'b1;
               state_d       = PLOT_ARM;
            end
         end
         PLOT_ARM: begin
            wd_clr  = 1'b1;
            state_d = PLOT_WAIT;
         end
         PLOT_WAIT: begin
            if (bus.logic_ready) begin
               state_d = SWAP_WAIT;
            end else if (wd == WD_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         SWAP_WAIT: begin
            if (bus.vsync) begin
               state_d = SWAP;
            end
         end
         SWAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wd            <= '0;
         pending       <= 1'b0;
         error_q       <= 1'b0;
         fill_start_q  <= 1'b0;
         logic_start_q <= 1'b0;
         frames        <= '0;
      end else begin
         state         <= state_d;
         fill_start_q  <= fill_start_d;
         logic_start_q <= logic_start_d;
         if (wd_clr) begin
            wd <= '0;
         end else if (state == CLEAR_WAIT || state == PLOT_WAIT) begin
            wd <= wd + 1'b1;
         end
         if (timeout || accept) begin
            pending <= 1'b0;
         end else if (bus.redraw_req && state != IDLE) begin
            pending <= 1'b1;
         end
         if (timeout) begin
            error_q <= 1'b1;
         end else if (accept) begin
            error_q <= 1'b0;
         end
         if (state == SWAP) begin
            frames <= frames + 1'b1;
         end
      end
   end

   logic                  sel_fill;
   logic                  sel_line;
   logic                  mux_we;
   logic [ADDR_WIDTH-1:0] mux_addr;
   logic                  mux_data;

   assign sel_fill = (state == CLEAR_ARM) || (state == CLEAR_WAIT);
   assign sel_line = (state == PLOT_ARM) || (state == PLOT_WAIT);

   always_comb begin
      mux_we   = 1'b0;
      mux_addr = '0;
      mux_data = 1'b0;
      if (sel_fill) begin
         mux_we   = bus.fill_we;
         mux_addr = bus.fill_addr;
         mux_data = bus.fill_data;
      end else if (sel_line) begin
         mux_we   = bus.line_we;
         mux_addr = bus.line_addr;
         mux_data = bus.line_data;
      end
   end

   assign bus.fb_we       = mux_we;
   assign bus.fb_addr     = mux_addr;
   assign bus.fb_data     = mux_data;
   assign bus.fill_start  = fill_start_q;
   assign bus.logic_start = logic_start_q;
   assign bus.swap        = (state == SWAP);
   assign bus.busy        = (state != IDLE);
   assign bus.error       = error_q;
   assign bus.frame_count = frames;
endmodule
